score_renderer: RTL and testbench

- Parametrised successor to the two-digit score overlay. Renders an N-digit decimal score as 8x16 font glyphs at a configurable screen origin with integer power-of-two scaling.
- A sequential double-dabble engine converts binary to BCD. Conversion is frame-synchronous, so the displayed digits never tear mid-frame.
- Sits between the game-state score counter and the colour mapper. Drives an external synchronous font ROM.

---
 rtl/score_renderer.sv | 202 ++++++++++++++++++++
 tb/tb_score_renderer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_renderer.sv
// rtl/score_renderer.sv - N-digit decimal score overlay with frame-synchronous BCD conversion
//
// Purpose: converts the binary game score to BCD with a sequential double-dabble engine
// once per frame, then renders the digits as 8x16 font glyphs read from an external
// synchronous font ROM, magnified by 2^SCALE_LOG2 at a fixed screen origin.
//
// Ports:
//   Clk, Reset_n        pixel clock, asynchronous active-low reset
//   score               binary score from game logic
//   frame_start         one-cycle pulse at start of vertical blank; starts a conversion
//   drawX, drawY        current pixel coordinate
//   font_addr           font ROM address {ascii[6:0], row[3:0]} (combinational)
//   font_data           glyph row returned by the ROM one cycle after font_addr
//   pixel_on            foreground pixel for the coordinate presented two cycles earlier
//   busy                conversion in progress
//
// Optional feature macro: SCORE_LEADING_ZERO_BLANK_EN (blank leading zero digits).

module score_renderer #(
    parameter int NUM_DIGITS = 4,
    parameter int SCORE_W    = 14,
    parameter int ORIGIN_X   = 8,
    parameter int ORIGIN_Y   = 0,
    parameter int SCALE_LOG2 = 0
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [SCORE_W-1:0] score,
    input  logic               frame_start,
    input  logic [9:0]         drawX,
    input  logic [9:0]         drawY,
    output logic [10:0]        font_addr,
    input  logic [7:0]         font_data,
    output logic               pixel_on,
    output logic               busy
);

    localparam int BCD_W   = 4 * NUM_DIGITS;
    localparam int FIELD_W = (NUM_DIGITS * 8) << SCALE_LOG2;
    localparam int FIELD_H = 16 << SCALE_LOG2;

    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam int SAT_LIMIT = pow10(NUM_DIGITS);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [4:0]         r_cnt;
    logic [SCORE_W-1:0] r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_sat;
    logic [BCD_W-1:0]   r_disp;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [31:0]        w_score_ext;

    logic               r_in_field_d;
    logic               r_blank_d;
    logic [2:0]         r_bitsel_d;
    logic               r_pixel_on;

    assign w_score_ext = 32'(score);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (frame_start) w_state_next = S_SHIFT;
            S_SHIFT: if (r_cnt == 5'(SCORE_W - 1)) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Double-dabble correction: any nibble >= 5 would exceed 9 after doubling.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] r_blank;
    logic [NUM_DIGITS-1:0] w_blank_calc;
    logic                  w_lead;

    // Digit 0 is the most significant; the last digit is always drawn.
    always_comb begin
        w_blank_calc = '0;
        w_lead       = 1'b1;
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            if (w_lead && (r_bcd[4*(NUM_DIGITS-1-i) +: 4] == 4'd0)) w_blank_calc[i] = 1'b1;
            else w_lead = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_blank <= '0;
        else if (r_state == S_DONE) r_blank <= r_sat ? '0 : w_blank_calc;
    end
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_sat   <= 1'b0;
            r_disp  <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_bin <= score;
                        r_bcd <= '0;
                        r_cnt <= '0;
                        r_sat <= (w_score_ext >= 32'(SAT_LIMIT));
                    end
                end
                S_SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                    r_cnt          <= r_cnt + 5'd1;
                end
                S_DONE: begin
                    r_disp <= r_sat ? {NUM_DIGITS{4'h9}} : r_bcd;
                end
                default: ;
            endcase
        end
    end

    // Stage 0: field decode and font address from the current coordinate.
    logic [10:0] w_dx;
    logic [10:0] w_dy;
    logic [10:0] w_col;
    logic [3:0]  w_row;
    logic [7:0]  w_digit;
    logic        w_in_field;
    logic [3:0]  w_nib;
    logic        w_blank_digit;
    logic [2:0]  w_bitsel;

    // A negative difference wraps to bit 10 set, which marks out-of-field.
    assign w_dx     = {1'b0, drawX} - 11'(ORIGIN_X);
    assign w_dy     = {1'b0, drawY} - 11'(ORIGIN_Y);
    assign w_col    = w_dx >> SCALE_LOG2;
    assign w_row    = w_dy[SCALE_LOG2 +: 4];
    assign w_digit  = w_col[10:3];
    assign w_bitsel = 3'd7 - w_col[2:0];

    assign w_in_field = !w_dx[10] && (w_dx < 11'(FIELD_W)) &&
                        !w_dy[10] && (w_dy < 11'(FIELD_H)) &&
                        (w_digit < 8'(NUM_DIGITS));

    always_comb begin
        w_nib         = 4'd0;
        w_blank_digit = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_digit == 8'(i)) begin
                w_nib = r_disp[4*(NUM_DIGITS-1-i) +: 4];
`ifdef SCORE_LEADING_ZERO_BLANK_EN
                w_blank_digit = r_blank[i];
`endif
            end
        end
    end

    always_comb begin
        font_addr = {7'h20, 4'h0};
        if (w_in_field) begin
            if (w_blank_digit) font_addr = {7'h20, w_row};
            else               font_addr = {7'h30 + {3'b000, w_nib}, w_row};
        end
    end

    // Stage 1 holds the decode while the ROM returns the row; output stage registers the pixel.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_in_field_d <= 1'b0;
            r_blank_d    <= 1'b0;
            r_bitsel_d   <= 3'd0;
            r_pixel_on   <= 1'b0;
        end else begin
            r_in_field_d <= w_in_field;
            r_blank_d    <= w_blank_digit;
            r_bitsel_d   <= w_bitsel;
            r_pixel_on   <= r_in_field_d & ~r_blank_d & font_data[r_bitsel_d];
        end
    end

    assign pixel_on = r_pixel_on;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_score_renderer.sv
// tb/tb_score_renderer.sv - directed self-checking bench for score_renderer
module tb_score_renderer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] score;
    logic        fs;
    logic [9:0]  dx, dy;
    logic [10:0] fa1, fa2;
    logic [7:0]  fd1, fd2;
    logic        px1, px2, busy1, busy2;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_val = 0;

    always #5 clk = ~clk;

    score_renderer u_dut (
        .Clk(clk), .Reset_n(rst_n), .score(score), .frame_start(fs),
        .drawX(dx), .drawY(dy), .font_addr(fa1), .font_data(fd1),
        .pixel_on(px1), .busy(busy1)
    );

    score_renderer #(.SCALE_LOG2(1)) u_dut2 (
        .Clk(clk), .Reset_n(rst_n), .score(score), .frame_start(fs),
        .drawX(dx), .drawY(dy), .font_addr(fa2), .font_data(fd2),
        .pixel_on(px2), .busy(busy2)
    );

    function automatic logic [7:0] glyph(input logic [10:0] a);
        return a[7:0] ^ {a[10:4], 1'b1};
    endfunction

    always @(posedge clk) begin
        fd1 <= glyph(fa1);
        fd2 <= glyph(fa2);
    end

    // Expected address/pixel for the default geometry (origin 8,0; 4 digits; scale 1).
    function automatic void model(input int x, input int y, input int val,
                                  output logic [10:0] efa, output logic epx);
        int d[4];
        logic bl[4];
        int tmp, col, dig, bt;
        logic lead;
        logic [7:0] g;
        tmp = val;
        for (int i = 3; i >= 0; i--) begin
            d[i] = tmp % 10;
            tmp = tmp / 10;
        end
        for (int i = 0; i < 4; i++) bl[i] = 1'b0;
        lead = 1'b1;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        for (int i = 0; i < 3; i++) begin
            if (lead && d[i] == 0) bl[i] = 1'b1;
            else lead = 1'b0;
        end
`endif
        efa = 11'h200;
        epx = 1'b0;
        if (x >= 8 && x < 40 && y >= 0 && y < 16) begin
            col = x - 8;
            dig = col / 8;
            bt  = 7 - (col % 8);
            if (bl[dig]) begin
                efa = 11'((32 << 4) | y);
            end else begin
                efa = 11'(((48 + d[dig]) << 4) | y);
                g   = glyph(efa);
                epx = g[bt];
            end
        end
    endfunction

    task automatic scan_field(input string tag);
        int ys[3] = '{3, 15, 16};
        logic q[$];
        logic e;
        logic [10:0] efa;
        logic epx;
        for (int yi = 0; yi < 3; yi++) begin
            for (int x = 6; x <= 42; x++) begin
                @(posedge clk); #1;
                if (q.size() == 2) begin
                    e = q.pop_front();
                    n_cmp++;
                    if (px1 !== e) begin
                        n_bad++;
                        $display("FAIL %s pixel_on (2 cycles before x=%0d y=%0d) got %b want %b", tag, x, ys[yi], px1, e);
                    end
                end
                dx = 10'(x);
                dy = 10'(ys[yi]);
                #1;
                model(x, ys[yi], exp_val, efa, epx);
                n_cmp++;
                if (fa1 !== efa) begin
                    n_bad++;
                    $display("FAIL %s font_addr x=%0d y=%0d got %h want %h", tag, x, ys[yi], fa1, efa);
                end
                q.push_back(epx);
            end
        end
        repeat (2) begin
            @(posedge clk); #1;
            e = q.pop_front();
            n_cmp++;
            if (px1 !== e) begin
                n_bad++;
                $display("FAIL %s pixel_on tail got %b want %b", tag, px1, e);
            end
        end
    endtask

    task automatic pulse_frame;
        @(posedge clk); #1 fs = 1'b1;
        @(posedge clk); #1 fs = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (busy1 !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy timeout got %b want 0", tag, busy1);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; fs = 1'b0; score = '0; dx = '0; dy = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy1); end
        n_cmp++; if (px1 !== 1'b0) begin n_bad++; $display("FAIL reset_pixel got %b want 0", px1); end
        n_cmp++; if (fa1 !== 11'h200) begin n_bad++; $display("FAIL reset_font_addr got %h want 200", fa1); end
        n_cmp++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL reset_busy2 got %b want 0", busy2); end
        @(posedge clk); #1 rst_n = 1'b1;
        exp_val = 0;
        scan_field("reset_scan");
    endtask

    task automatic test_convert;
        int cnt;
        logic [10:0] prev;
        dx = 10'd8; dy = 10'd0; score = 14'd1234;
        pulse_frame();
        cnt = 0;
        prev = fa1;
        while (busy1 && cnt < 100) begin
            prev = fa1;
            @(posedge clk); #1;
            cnt++;
        end
        n_cmp++; if (cnt != 15) begin n_bad++; $display("FAIL convert_busy_cycles got %0d want 15", cnt); end
        n_cmp++; if (prev !== 11'h300) begin n_bad++; $display("FAIL convert_old_during_done got %h want 300", prev); end
        n_cmp++; if (fa1 !== 11'h310) begin n_bad++; $display("FAIL convert_new_after_done got %h want 310", fa1); end
        exp_val = 1234;
        scan_field("convert_1234");
    endtask

    task automatic test_saturate;
        score = 14'd12000;
        pulse_frame();
        wait_idle("saturate");
        exp_val = 9999;
        scan_field("saturate_9999");
    endtask

    task automatic test_hold;
        score = 14'd77;
        repeat (40) @(posedge clk);
        #1;
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL hold_busy got %b want 0", busy1); end
        exp_val = 9999;
        scan_field("hold_no_frame");
    endtask

    task automatic test_back_to_back;
        int highs;
        score = 14'd56;
        pulse_frame();
        repeat (3) @(posedge clk);
        #1 score = 14'd77;
        pulse_frame();
        wait_idle("b2b_first");
        highs = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy1) highs++;
        end
        n_cmp++; if (highs != 0) begin n_bad++; $display("FAIL b2b_no_second_conv got %0d busy cycles want 0", highs); end
        exp_val = 56;
        scan_field("b2b_0056");
        pulse_frame();
        wait_idle("b2b_second");
        exp_val = 77;
        scan_field("b2b_0077");
    endtask

    task automatic test_scale;
        int xs[4] = '{25, 72, 71, 71};
        int ys[4] = '{5, 5, 31, 32};
        logic [10:0] efas[4] = '{11'h322, 11'h200, 11'h34F, 11'h200};
        int bits[4] = '{7, 0, 0, 0};
        logic inf[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] g;
        logic epx;
        score = 14'd1234;
        pulse_frame();
        wait_idle("scale");
        n_cmp++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL scale_busy2 got %b want 0", busy2); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            dx = 10'(xs[i]); dy = 10'(ys[i]);
            #1;
            n_cmp++;
            if (fa2 !== efas[i]) begin
                n_bad++;
                $display("FAIL scale_font_addr x=%0d y=%0d got %h want %h", xs[i], ys[i], fa2, efas[i]);
            end
            g = glyph(efas[i]);
            epx = inf[i] ? g[bits[i]] : 1'b0;
            @(posedge clk);
            @(posedge clk); #1;
            n_cmp++;
            if (px2 !== epx) begin
                n_bad++;
                $display("FAIL scale_pixel x=%0d y=%0d got %b want %b", xs[i], ys[i], px2, epx);
            end
        end
    endtask

    task automatic test_reset_abort;
        score = 14'd1234;
        pulse_frame();
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy1); end
        n_cmp++; if (px1 !== 1'b0) begin n_bad++; $display("FAIL abort_pixel got %b want 0", px1); end
        @(posedge clk); #1 rst_n = 1'b1;
        exp_val = 0;
        scan_field("abort_0000");
    endtask

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    task automatic test_blank;
        score = 14'd7;
        pulse_frame();
        wait_idle("blank7");
        exp_val = 7;
        scan_field("blank_7");
        score = 14'd0;
        pulse_frame();
        wait_idle("blank0");
        exp_val = 0;
        scan_field("blank_0");
    endtask
`endif

    initial begin
        test_reset();
        test_convert();
        test_saturate();
        test_hold();
        test_back_to_back();
        test_scale();
        test_reset_abort();
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        test_blank();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
